// File: rtl/rob_multiport_pkg.sv
// Shared types and defaults for the multi-port reorder buffer.
// Build option: ROB_STORE_ACK_EN gates head-store retirement on store_ack.
package rob_pkg;

  localparam int D_DEPTH  = 16;
  localparam int D_DISP_W = 2;
  localparam int D_RET_W  = 2;
  localparam int D_CDB_W  = 2;
  localparam int XLEN     = 32;
  localparam int REG_LEN  = 5;

  typedef struct packed {
    logic               done;
    logic               wb_en;
    logic               mispredict;
    logic               halt;
    logic               illegal;
    logic               is_store;
    logic [REG_LEN-1:0] dest_idx;
    logic [XLEN-1:0]    value;
    logic [XLEN-1:0]    pc;
  } rob_entry_t;

  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rob_multiport_if.sv
// Dispatch / completion / retire bundle between core and reorder buffer.
// Build option: ROB_STORE_ACK_EN makes store_ack meaningful.
interface rob_if
  import rob_pkg::*;
#(
  parameter int DEPTH  = D_DEPTH,
  parameter int DISP_W = D_DISP_W,
  parameter int RET_W  = D_RET_W,
  parameter int CDB_W  = D_CDB_W
);
  localparam int TAG_W = tag_w(DEPTH);

  logic                      stall;
  logic [DISP_W-1:0]         disp_valid;
  logic [DISP_W*REG_LEN-1:0] disp_dest_idx;
  logic [DISP_W*XLEN-1:0]    disp_pc;
  logic [DISP_W-1:0]         disp_halt;
  logic [DISP_W-1:0]         disp_illegal;
  logic [DISP_W-1:0]         disp_is_store;
  logic                      disp_ready;
  logic [DISP_W*TAG_W-1:0]   disp_tag;

  logic [CDB_W-1:0]          cdb_valid;
  logic [CDB_W*TAG_W-1:0]    cdb_tag;
  logic [CDB_W*XLEN-1:0]     cdb_value;
  logic [CDB_W-1:0]          cdb_wb_en;
  logic [CDB_W-1:0]          cdb_mispredict;

  logic [2*TAG_W-1:0]        rd_tag;
  logic [2*XLEN-1:0]         rd_value;

  logic [TAG_W-1:0]          head_tag;
  logic [TAG_W:0]            free_count;
  logic [RET_W-1:0]          ret_valid;
  logic [RET_W-1:0]          ret_wb_en;
  logic [RET_W-1:0]          ret_halt;
  logic [RET_W-1:0]          ret_illegal;
  logic [RET_W*REG_LEN-1:0]  ret_dest_idx;
  logic [RET_W*XLEN-1:0]     ret_value;
  logic [RET_W*XLEN-1:0]     ret_pc;
  logic                      squash;
  logic                      halted;
  logic                      store_start;
  logic                      store_ack;

  modport master (
    output stall, disp_valid, disp_dest_idx, disp_pc,
    output disp_halt, disp_illegal, disp_is_store,
    output cdb_valid, cdb_tag, cdb_value, cdb_wb_en,
    output cdb_mispredict, rd_tag, store_ack,
    input  disp_ready, disp_tag, rd_value, head_tag,
    input  free_count, ret_valid, ret_wb_en, ret_halt,
    input  ret_illegal, ret_dest_idx, ret_value, ret_pc,
    input  squash, halted, store_start
  );

  modport slave (
    input  stall, disp_valid, disp_dest_idx, disp_pc,
    input  disp_halt, disp_illegal, disp_is_store,
    input  cdb_valid, cdb_tag, cdb_value, cdb_wb_en,
    input  cdb_mispredict, rd_tag, store_ack,
    output disp_ready, disp_tag, rd_value, head_tag,
    output free_count, ret_valid, ret_wb_en, ret_halt,
    output ret_illegal, ret_dest_idx, ret_value, ret_pc,
    output squash, halted, store_start
  );

endinterface

// File: rtl/rob_multiport_retire_sel.sv
// In-order retire prefix: a slot retires only behind retiring slots.
// Build option: ROB_STORE_ACK_EN holds a head store until store_ack.
module rob_retire_sel #(
  parameter int RET_W = 2
) (
  input  logic [RET_W-1:0] i_occ,
  input  logic [RET_W-1:0] i_done,
  input  logic [RET_W-1:0] i_mispredict,
  input  logic [RET_W-1:0] i_halt,
  input  logic [RET_W-1:0] i_is_store,
  input  logic             i_halted,
  input  logic             i_store_ack,
  output logic [RET_W-1:0] o_valid,
  output logic             o_squash,
  output logic             o_halt
);

  logic w_go;
  logic w_ok;

`ifndef ROB_STORE_ACK_EN
  logic w_unused;
  assign w_unused = i_store_ack | (|i_is_store);
`endif

  // Walk slots oldest first; a mispredict or halt closes the group
  always_comb begin
    w_go     = !i_halted;
    w_ok     = 1'b0;
    o_valid  = '0;
    o_squash = 1'b0;
    o_halt   = 1'b0;
    for (int j = 0; j < RET_W; j++) begin
      w_ok = w_go & i_occ[j] & i_done[j];
`ifdef ROB_STORE_ACK_EN
      if (i_is_store[j])
        w_ok = (j == 0) ? (w_ok & i_store_ack) : 1'b0;
`endif
      o_valid[j] = w_ok;
      o_squash   = o_squash | (w_ok & i_mispredict[j]);
      o_halt     = o_halt | (w_ok & i_halt[j]);
      w_go       = w_ok & ~i_mispredict[j] & ~i_halt[j];
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Multi-issue reorder buffer with occupancy count, squash and halt.
// Build option: ROB_STORE_ACK_EN enables the store-commit handshake.
module rob_multiport
  import rob_pkg::*;
#(
  parameter int DEPTH  = D_DEPTH,
  parameter int DISP_W = D_DISP_W,
  parameter int RET_W  = D_RET_W,
  parameter int CDB_W  = D_CDB_W
) (
  input logic clock,
  input logic reset,
  rob_if.slave bus
);

  localparam int TAG_W = tag_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  rob_entry_t r_ent [DEPTH];
  tag_t       r_head;
  tag_t       r_tail;
  cnt_t       r_count;
  cnt_t       r_free;
  logic       r_halted;

  tag_t       w_ret_tag [RET_W];
  logic [RET_W-1:0] w_occ;
  logic [RET_W-1:0] w_done;
  logic [RET_W-1:0] w_misp;
  logic [RET_W-1:0] w_halt;
  logic [RET_W-1:0] w_store;
  logic [RET_W-1:0] w_ret;
  logic       w_squash;
  logic       w_halt_ret;
  cnt_t       w_ndisp;
  cnt_t       w_nacc;
  cnt_t       w_nret;
  logic       w_disp_ok;
  tag_t       w_head_new;
  tag_t       w_cdb_tag [CDB_W];
  logic [CDB_W-1:0] w_cdb_occ;
  rob_entry_t w_new [DISP_W];

  // Head-relative retire candidates
  always_comb begin
    w_occ   = '0;
    w_done  = '0;
    w_misp  = '0;
    w_halt  = '0;
    w_store = '0;
    for (int j = 0; j < RET_W; j++) begin
      w_ret_tag[j] = r_head + tag_t'(j);
      w_occ[j]     = cnt_t'(j) < r_count;
      w_done[j]    = r_ent[w_ret_tag[j]].done;
      w_misp[j]    = r_ent[w_ret_tag[j]].mispredict;
      w_halt[j]    = r_ent[w_ret_tag[j]].halt;
      w_store[j]   = r_ent[w_ret_tag[j]].is_store;
    end
  end

  rob_retire_sel #(.RET_W(RET_W)) u_sel (
    .i_occ        (w_occ),
    .i_done       (w_done),
    .i_mispredict (w_misp),
    .i_halt       (w_halt),
    .i_is_store   (w_store),
    .i_halted     (r_halted),
    .i_store_ack  (bus.store_ack),
    .o_valid      (w_ret),
    .o_squash     (w_squash),
    .o_halt       (w_halt_ret)
  );

  // Dispatch/retire counts and completion occupancy
  always_comb begin
    w_ndisp = '0;
    w_nret  = '0;
    for (int i = 0; i < DISP_W; i++)
      w_ndisp = w_ndisp + cnt_t'(bus.disp_valid[i]);
    for (int j = 0; j < RET_W; j++)
      w_nret = w_nret + cnt_t'(w_ret[j]);
    w_cdb_occ = '0;
    for (int k = 0; k < CDB_W; k++) begin
      w_cdb_tag[k] = bus.cdb_tag[k*TAG_W +: TAG_W];
      w_cdb_occ[k] = cnt_t'(tag_t'(w_cdb_tag[k] - r_head)) < r_count;
    end
  end

  assign w_disp_ok  = (r_free >= w_ndisp) && !bus.stall &&
                      !w_squash && !r_halted;
  assign w_nacc     = w_disp_ok ? w_ndisp : '0;
  assign w_head_new = r_head + w_nret[TAG_W-1:0];

  // Fresh entries for accepted dispatch slots
  always_comb begin
    for (int i = 0; i < DISP_W; i++) begin
      w_new[i]          = '0;
      w_new[i].halt     = bus.disp_halt[i];
      w_new[i].illegal  = bus.disp_illegal[i];
      w_new[i].is_store = bus.disp_is_store[i];
      w_new[i].dest_idx = bus.disp_dest_idx[i*REG_LEN +: REG_LEN];
      w_new[i].pc       = bus.disp_pc[i*XLEN +: XLEN];
    end
  end

  // Outputs straight from state
  always_comb begin
    bus.disp_tag     = '0;
    bus.rd_value     = '0;
    bus.ret_valid    = w_ret;
    bus.ret_wb_en    = '0;
    bus.ret_halt     = '0;
    bus.ret_illegal  = '0;
    bus.ret_dest_idx = '0;
    bus.ret_value    = '0;
    bus.ret_pc       = '0;
    for (int i = 0; i < DISP_W; i++)
      bus.disp_tag[i*TAG_W +: TAG_W] = r_tail + tag_t'(i);
    for (int r = 0; r < 2; r++)
      bus.rd_value[r*XLEN +: XLEN] =
        r_ent[bus.rd_tag[r*TAG_W +: TAG_W]].value;
    for (int j = 0; j < RET_W; j++) begin
      if (w_ret[j]) begin
        bus.ret_wb_en[j]   = r_ent[w_ret_tag[j]].wb_en;
        bus.ret_halt[j]    = r_ent[w_ret_tag[j]].halt;
        bus.ret_illegal[j] = r_ent[w_ret_tag[j]].illegal;
        bus.ret_dest_idx[j*REG_LEN +: REG_LEN] =
          r_ent[w_ret_tag[j]].dest_idx;
        bus.ret_value[j*XLEN +: XLEN] = r_ent[w_ret_tag[j]].value;
        bus.ret_pc[j*XLEN +: XLEN]    = r_ent[w_ret_tag[j]].pc;
      end
    end
  end

  assign bus.disp_ready  = w_disp_ok;
  assign bus.head_tag    = r_head;
  assign bus.free_count  = r_free;
  assign bus.squash      = w_squash;
  assign bus.halted      = r_halted;
  assign bus.store_start = w_occ[0] & w_store[0] & w_done[0];

  // Entry array, pointers and occupancy; later writes take priority
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < DEPTH; e++)
        r_ent[e] <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_free   <= cnt_t'(DEPTH);
      r_halted <= 1'b0;
    end else begin
      for (int k = 0; k < CDB_W; k++) begin
        if (bus.cdb_valid[k] && w_cdb_occ[k]) begin
          r_ent[w_cdb_tag[k]].done       <= 1'b1;
          r_ent[w_cdb_tag[k]].wb_en      <= bus.cdb_wb_en[k];
          r_ent[w_cdb_tag[k]].mispredict <= bus.cdb_mispredict[k];
          if (bus.cdb_wb_en[k])
            r_ent[w_cdb_tag[k]].value <= bus.cdb_value[k*XLEN +: XLEN];
        end
      end
      for (int j = 0; j < RET_W; j++) begin
        if (w_ret[j]) begin
          r_ent[w_ret_tag[j]].done       <= 1'b0;
          r_ent[w_ret_tag[j]].mispredict <= 1'b0;
        end
      end
      if (w_disp_ok) begin
        for (int i = 0; i < DISP_W; i++)
          if (bus.disp_valid[i])
            r_ent[r_tail + tag_t'(i)] <= w_new[i];
      end
      r_head   <= w_head_new;
      r_halted <= r_halted | w_halt_ret;
      if (w_squash) begin
        for (int e = 0; e < DEPTH; e++) begin
          r_ent[e].done       <= 1'b0;
          r_ent[e].mispredict <= 1'b0;
        end
        r_tail  <= w_head_new;
        r_count <= '0;
        r_free  <= cnt_t'(DEPTH);
      end else begin
        r_tail  <= r_tail + w_nacc[TAG_W-1:0];
        r_count <= r_count + w_nacc - w_nret;
        r_free  <= r_free - w_nacc + w_nret;
      end
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: fill, OOO, wrap, squash, store, halt.
// Build option: ROB_STORE_ACK_EN switches the store-step expectations.
module tb_rob_multiport;
  import rob_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DISP_W = 2;
  localparam int RET_W  = 2;
  localparam int CDB_W  = 2;
  localparam int TAG_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rob_if #(.DEPTH(DEPTH), .DISP_W(DISP_W), .RET_W(RET_W),
           .CDB_W(CDB_W)) bus ();

  rob_multiport #(.DEPTH(DEPTH), .DISP_W(DISP_W), .RET_W(RET_W),
                  .CDB_W(CDB_W)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] pc_of(input logic [TAG_W-1:0] t);
    return 32'h1000 + {26'd0, t, 2'b00};
  endfunction

  function automatic logic [31:0] val_of(input logic [TAG_W-1:0] t);
    return 32'hA000 + {28'd0, t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall          = 1'b0;
    bus.disp_valid     = '0;
    bus.disp_dest_idx  = '0;
    bus.disp_pc        = '0;
    bus.disp_halt      = '0;
    bus.disp_illegal   = '0;
    bus.disp_is_store  = '0;
    bus.cdb_valid      = '0;
    bus.cdb_tag        = '0;
    bus.cdb_value      = '0;
    bus.cdb_wb_en      = '0;
    bus.cdb_mispredict = '0;
    bus.rd_tag         = '0;
    bus.store_ack      = 1'b0;
  endtask

  task automatic disp2(input logic [TAG_W-1:0] t,
                       input logic [1:0] halt, input logic [1:0] st);
    logic [TAG_W-1:0] t1;
    t1 = t + 4'd1;
    bus.disp_valid    = 2'b11;
    bus.disp_halt     = halt;
    bus.disp_is_store = st;
    bus.disp_dest_idx = {1'b0, t1, 1'b0, t};
    bus.disp_pc       = {pc_of(t1), pc_of(t)};
    #1;
    chk("disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("disp_tag", 64'(bus.disp_tag), 64'({t1, t}));
    tick();
    idle();
  endtask

  task automatic comp2(input logic [TAG_W-1:0] t0,
                       input logic [TAG_W-1:0] t1,
                       input logic [1:0] misp, input logic [1:0] wb);
    bus.cdb_valid      = 2'b11;
    bus.cdb_tag        = {t1, t0};
    bus.cdb_value      = {val_of(t1), val_of(t0)};
    bus.cdb_wb_en      = wb;
    bus.cdb_mispredict = misp;
    tick();
    idle();
  endtask

  initial begin
    idle();
    #12;
    chk("rst_free", 64'(bus.free_count), 64'd16);
    chk("rst_head", 64'(bus.head_tag), 64'd0);
    chk("rst_ret_valid", 64'(bus.ret_valid), 64'd0);
    chk("rst_squash", 64'(bus.squash), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    bus.stall = 1'b1;
    bus.disp_valid = 2'b11;
    #1;
    chk("stall_ready", 64'(bus.disp_ready), 64'd0);
    idle();

    for (int c = 0; c < 8; c++)
      disp2(4'(2 * c), 2'b00, 2'b00);
    bus.disp_valid = 2'b11;
    #1;
    chk("full_free", 64'(bus.free_count), 64'd0);
    chk("full_ready", 64'(bus.disp_ready), 64'd0);
    idle();

    for (int c = 0; c < 8; c++) begin
      bus.cdb_valid = 2'b11;
      bus.cdb_tag   = {4'(2 * c + 1), 4'(2 * c)};
      bus.cdb_value = {val_of(4'(2 * c + 1)), val_of(4'(2 * c))};
      bus.cdb_wb_en = 2'b11;
      #1;
      chk("drain_valid", 64'(bus.ret_valid),
          (c > 0) ? 64'd3 : 64'd0);
      if (c > 0)
        chk("drain_value", bus.ret_value,
            {val_of(4'(2 * c - 1)), val_of(4'(2 * c - 2))});
      tick();
      idle();
    end
    chk("drain_last_free", 64'(bus.free_count), 64'd14);
    chk("drain_last_pc", bus.ret_pc, {pc_of(4'd15), pc_of(4'd14)});
    tick();
    chk("empty_free", 64'(bus.free_count), 64'd16);
    chk("empty_valid", 64'(bus.ret_valid), 64'd0);
    chk("empty_head", 64'(bus.head_tag), 64'd0);

    disp2(4'd0, 2'b00, 2'b00);
    disp2(4'd2, 2'b00, 2'b00);
    comp2(4'd3, 4'd2, 2'b00, 2'b11);
    chk("ooo_hold_a", 64'(bus.ret_valid), 64'd0);
    bus.rd_tag = {4'd2, 4'd3};
    #1;
    chk("rd_value", bus.rd_value, {val_of(4'd2), val_of(4'd3)});
    bus.cdb_valid = 2'b11;
    bus.cdb_tag   = {4'd1, 4'd1};
    bus.cdb_value = {32'h22, 32'h11};
    bus.cdb_wb_en = 2'b11;
    tick();
    idle();
    chk("ooo_hold_b", 64'(bus.ret_valid), 64'd0);
    bus.cdb_valid = 2'b01;
    bus.cdb_tag   = {4'd0, 4'd9};
    bus.cdb_value = {32'h0, 32'hDEAD};
    bus.cdb_wb_en = 2'b01;
    tick();
    idle();
    bus.rd_tag = {4'd9, 4'd1};
    #1;
    chk("unocc_ignored", bus.rd_value, {val_of(4'd9), 32'h22});
    bus.cdb_valid = 2'b01;
    bus.cdb_tag   = {4'd0, 4'd0};
    bus.cdb_value = {32'h0, val_of(4'd0)};
    bus.cdb_wb_en = 2'b01;
    tick();
    idle();
    chk("ooo_ret01", 64'(bus.ret_valid), 64'd3);
    chk("ooo_val01", bus.ret_value, {32'h22, val_of(4'd0)});
    chk("ooo_dest01", 64'(bus.ret_dest_idx), 64'({5'd1, 5'd0}));
    tick();
    chk("ooo_ret23", 64'(bus.ret_valid), 64'd3);
    chk("ooo_val23", bus.ret_value, {val_of(4'd3), val_of(4'd2)});
    tick();
    chk("ooo_done", 64'(bus.ret_valid), 64'd0);
    chk("ooo_head", 64'(bus.head_tag), 64'd4);

    for (int c = 0; c < 5; c++)
      disp2(4'(4 + 2 * c), 2'b00, 2'b00);
    for (int c = 0; c < 5; c++)
      comp2(4'(4 + 2 * c), 4'(5 + 2 * c), 2'b00, 2'b11);
    tick();
    chk("wrap_head", 64'(bus.head_tag), 64'd14);
    chk("wrap_free", 64'(bus.free_count), 64'd16);
    disp2(4'd14, 2'b00, 2'b00);
    disp2(4'd0, 2'b00, 2'b00);
    comp2(4'd14, 4'd15, 2'b00, 2'b11);
    chk("wrap_ret_a", 64'(bus.ret_valid), 64'd3);
    chk("wrap_pc_a", bus.ret_pc, {pc_of(4'd15), pc_of(4'd14)});
    comp2(4'd0, 4'd1, 2'b00, 2'b11);
    chk("wrap_pc_b", bus.ret_pc, {pc_of(4'd1), pc_of(4'd0)});
    tick();
    chk("wrap_head2", 64'(bus.head_tag), 64'd2);

    disp2(4'd2, 2'b00, 2'b00);
    disp2(4'd4, 2'b00, 2'b00);
    disp2(4'd6, 2'b00, 2'b00);
    comp2(4'd2, 4'd3, 2'b10, 2'b01);
    bus.disp_valid = 2'b11;
    #1;
    chk("sq_ret", 64'(bus.ret_valid), 64'd3);
    chk("sq_pulse", 64'(bus.squash), 64'd1);
    chk("sq_ready", 64'(bus.disp_ready), 64'd0);
    chk("sq_wb", 64'(bus.ret_wb_en), 64'd1);
    tick();
    idle();
    chk("sq_end", 64'(bus.squash), 64'd0);
    chk("sq_free", 64'(bus.free_count), 64'd16);
    chk("sq_head", 64'(bus.head_tag), 64'd4);
    chk("sq_tail", 64'(bus.disp_tag), 64'h54);
    bus.cdb_valid = 2'b01;
    bus.cdb_tag   = {4'd0, 4'd5};
    tick();
    idle();
    chk("sq_stale", 64'(bus.ret_valid), 64'd0);

    disp2(4'd4, 2'b00, 2'b01);
    chk("st_pre", 64'(bus.store_start), 64'd0);
    comp2(4'd4, 4'd5, 2'b00, 2'b11);
    chk("st_start", 64'(bus.store_start), 64'd1);
`ifdef ROB_STORE_ACK_EN
    for (int c = 0; c < 3; c++) begin
      chk("st_wait_start", 64'(bus.store_start), 64'd1);
      chk("st_wait_ret", 64'(bus.ret_valid), 64'd0);
      tick();
    end
    bus.store_ack = 1'b1;
    #1;
`endif
    chk("st_ret", 64'(bus.ret_valid), 64'd3);
    tick();
    idle();
    chk("st_head", 64'(bus.head_tag), 64'd6);
    chk("st_clear", 64'(bus.store_start), 64'd0);

    disp2(4'd6, 2'b01, 2'b00);
    comp2(4'd6, 4'd7, 2'b00, 2'b11);
    chk("ht_ret", 64'(bus.ret_valid), 64'd1);
    chk("ht_flag", 64'(bus.ret_halt), 64'd1);
    chk("ht_pre", 64'(bus.halted), 64'd0);
    tick();
    chk("ht_halted", 64'(bus.halted), 64'd1);
    chk("ht_noret", 64'(bus.ret_valid), 64'd0);
    chk("ht_free", 64'(bus.free_count), 64'd15);
    bus.disp_valid = 2'b11;
    #1;
    chk("ht_ready", 64'(bus.disp_ready), 64'd0);
    tick();
    idle();
    chk("ht_hold", 64'(bus.ret_valid), 64'd0);
    chk("ht_head", 64'(bus.head_tag), 64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised reorder buffer, successor to the single-issue ROB.
- Accepts up to DISP_W in-order dispatches, CDB_W completions and RET_W in-order retirements per cycle.
- Uses occupancy counting, so full and empty are never ambiguous.
- Provides precise squash on a mispredicted head entry, a latched halt, and an optional store-commit handshake toward the store unit.

Parameters:
- DEPTH, 16, number of entries; power of 2, at least 4.
- DISP_W, 2, dispatch slots per cycle.
- RET_W, 2, retire slots per cycle.
- CDB_W, 2, completion ports per cycle.
- XLEN, 32, data width.
- REG_LEN, 5, architectural register index width.
- TAG_W, $clog2(DEPTH), entry tag width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  blocks dispatch this cycle.
- disp_valid  in  DISP_W  per-slot dispatch request; contiguous from slot 0.
- disp_dest_idx  in  DISP_W*REG_LEN  destination register per slot.
- disp_pc  in  DISP_W*XLEN  PC per slot.
- disp_halt, disp_illegal, disp_is_store  in  DISP_W each  per-slot flags.
- disp_ready  out  1  all requested slots accepted this cycle.
- disp_tag  out  DISP_W*TAG_W  tag assigned to each slot (tail+i).
- cdb_valid  in  CDB_W  completion strobe.
- cdb_tag  in  CDB_W*TAG_W  completing entry.
- cdb_value  in  CDB_W*XLEN  result.
- cdb_wb_en  in  CDB_W  result writes a register.
- cdb_mispredict  in  CDB_W  entry is a mispredicted branch.
- rd_tag  in  2*TAG_W  operand lookup tags.
- rd_value  out  2*XLEN  combinational value of the entries named by rd_tag.
- head_tag  out  TAG_W  oldest entry.
- free_count  out  TAG_W+1  free entries (registered).
- ret_valid, ret_wb_en, ret_halt, ret_illegal  out  RET_W each  retirement slots, oldest first.
- ret_dest_idx  out  RET_W*REG_LEN  retiring destination.
- ret_value  out  RET_W*XLEN  retiring value.
- ret_pc  out  RET_W*XLEN  retiring PC.
- squash  out  1  one-cycle flush pulse to RS/MT/fetch.
- halted  out  1  sticky; set once a halt has retired.
- store_start  out  1  head entry is an uncommitted store.
- store_ack  in  1  store unit committed the head store (feature only).

Behaviour:
- Reset (reset low, asynchronous):
  - head = tail = 0, count = 0, free_count = DEPTH.
  - All entry done/mispredict bits are 0.
  - squash = 0, halted = 0, all ret_* = 0.
- Dispatch:
  - n = popcount(disp_valid).
  - disp_ready = (free_count >= n) && !stall && !squash && !halted.
  - Dispatch is all-or-nothing. If disp_ready, slot i writes entry tail+i (mod DEPTH) and tail advances by n.
  - A written entry has done = 0 and value = 0.
- Completion:
  - When cdb_valid[k], the entry at cdb_tag[k] gets done = 1, wb_en = cdb_wb_en[k], mispredict = cdb_mispredict[k].
  - The value is written only if cdb_wb_en[k].
  - Completion is visible to retire the next cycle.
  - Two ports naming the same tag: the higher k wins.
  - A completion naming a non-occupied entry is ignored.
- Retire (combinational from registered state):
  - Slot j retires entry head+j only if slots 0..j-1 retire, that entry is occupied and done, and no earlier slot is a mispredict or halt.
  - A mispredicted or halt entry retires, then ends the group.
  - Retired entries clear done; head advances by the number retired.
- Squash:
  - If any retiring slot is a mispredict, squash = 1 that cycle.
  - Next edge: tail = head_new, count = 0, all done/mispredict bits cleared.
  - Dispatch in a squash cycle is rejected (disp_ready = 0).
- Halt:
  - Retiring a halt sets halted next edge; ret_halt is asserted on that slot.
  - After halt: no further retire or dispatch until reset.
- count_next = count + dispatched − retired; 0 ≤ count ≤ DEPTH at all times.
  - Dispatch and retire in the same cycle at full occupancy are legal, but dispatch uses pre-retire free_count.
- All pointer arithmetic wraps modulo DEPTH.
- Outputs are driven directly from state; there is no extra latency register.

Optional Feature:
- ROB_STORE_ACK_EN defined:
  - A done store at head (relative slot 0 only) asserts store_start and retires only in the cycle store_ack = 1.
  - Younger slots behind it in the same group are held.
  - Stores may not retire in slots 1..RET_W-1.
- Not defined:
  - store_ack is ignored; stores retire like ALU ops.
  - store_start = head occupied && is_store && done.

Decomposition:
- Package rob_pkg holds:
  - ROB_ENTRY struct: done, wb_en, mispredict, halt, illegal, is_store, dest_idx, value, pc.
  - Default DEPTH/DISP_W/RET_W/CDB_W constants.
  - Width helpers.
- Sub-module rob_retire_sel: combinational prefix selector producing the ret_valid mask and squash from RET_W head-relative entries.

Test Plan:
- Fill/empty: dispatch 2/cycle ×8 with DEPTH=16, no completion → free_count 0, disp_ready 0. Complete all, retire 2/cycle → free_count back to 16 after 8 cycles.
- Wrap: 14 dispatch, retire 14, dispatch 4 → tags 14, 15, 0, 1; retire order preserved.
- Out-of-order complete: tags 0..3 dispatched; complete 3, 2, 1 → no retire. Complete 0 → cycles retire {0,1} then {2,3}.
- Squash: tags 0..5 dispatched, tag 1 completes mispredict, tag 0 completes → retire 0 and 1, squash = 1 for one cycle; next cycle count = 0, tail = head = 2.
- Halt: halt at tag 0 completes with tag 1 done → ret_halt on slot 0 only; halted = 1; tag 1 never retires; disp_ready stays 0.
- Store ack (ROB_STORE_ACK_EN): done store at head, store_ack low 3 cycles → store_start held, no retire. Ack → retires next edge.
